// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types, widths and helpers for the memory port arbiter
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF       = 32;
  localparam int unsigned DATA_W_DEF       = 32;
  localparam int unsigned STARVE_LIMIT_DEF = 4;
  localparam int unsigned STARVE_CNT_W     = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_e;

  // The owner of the memory is implied by the state; kept as a helper so the
  // datapath reads in terms of who the response belongs to.
  function automatic arb_owner_e state_owner(arb_state_e s);
    case (s)
      BUSY_IF: return OWN_IF;
      BUSY_D:  return OWN_D;
      default: return OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational grant selection: data priority with optional IF starvation override
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                    window_i,
  input  logic                    if_req_i,
  input  logic                    d_req_i,
  input  logic [STARVE_CNT_W-1:0] starve_cnt_i,
  output logic                    if_gnt_o,
  output logic                    d_gnt_o
);

  logic if_first;

  // One-hot grant: data wins unless IF has waited through STARVE_LIMIT data
  // grants. A zero limit disables the override rather than forcing IF forever.
  always_comb begin
    if_first = (STARVE_LIMIT != 0) && (32'(starve_cnt_i) >= STARVE_LIMIT);
    d_gnt_o  = window_i & d_req_i & ~(if_first & if_req_i);
    if_gnt_o = window_i & if_req_i & ~d_gnt_o;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/data arbiter for a single-port variable-latency memory (optional MEMARB_STARVE_GUARD_EN)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  arb_state_e              state_q, state_d;
  arb_owner_e              owner;
  logic                    window;
  logic                    complete;
  logic                    if_gnt, d_gnt;
  logic [STARVE_CNT_W-1:0] starve_cnt;

  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  // A ready seen without an outstanding request is ignored.
  assign complete = mem_req_q & mem_ready_i;

  mem_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .window_i    (window),
    .if_req_i    (if_req_i),
    .d_req_i     (d_req_i),
    .starve_cnt_i(starve_cnt),
    .if_gnt_o    (if_gnt),
    .d_gnt_o     (d_gnt)
  );

`ifdef MEMARB_STARVE_GUARD_EN
  logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  // Count data grants that IF sat through; any IF grant or IF idling clears it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req_i || if_gnt) begin
      starve_cnt_d = '0;
    end else if (d_gnt && (starve_cnt_q != '1)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign starve_cnt = starve_cnt_q;
`else
  assign starve_cnt = '0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a grant always moves ownership; a completion without a
  // follow-on grant returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (d_gnt) begin
      state_d = BUSY_D;
    end else if (if_gnt) begin
      state_d = BUSY_IF;
    end else if (complete) begin
      state_d = IDLE;
    end
  end

  // FSM outputs: grant window, owner and busy flag.
  always_comb begin
    owner  = state_owner(state_q);
    window = (state_q == IDLE) | complete;
    busy_o = (state_q != IDLE);
  end

  // Memory issue and response next-state: latch the granted port, hold
  // everything while the access waits, route read data back to its owner.
  always_comb begin
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rvalid_d  = 1'b0;
    d_rdata_d   = d_rdata_q;

    if (d_gnt) begin
      mem_req_d   = 1'b1;
      mem_we_d    = d_we_i;
      mem_addr_d  = d_addr_i;
      mem_wdata_d = d_wdata_i;
    end else if (if_gnt) begin
      mem_req_d   = 1'b1;
      mem_we_d    = 1'b0;
      mem_addr_d  = if_addr_i;
      mem_wdata_d = '0;
    end else if (complete) begin
      mem_req_d   = 1'b0;
    end

    if (complete) begin
      if (owner == OWN_IF) begin
        if_rvalid_d = 1'b1;
        if_rdata_d  = mem_rdata_i;
      end else if (owner == OWN_D) begin
        d_rvalid_d  = 1'b1;
        d_rdata_d   = mem_we_q ? '0 : mem_rdata_i;
      end
    end
  end

  // Memory issue and response registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rvalid_q  <= d_rvalid_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign if_gnt_o    = if_gnt;
  assign d_gnt_o     = d_gnt;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rvalid_o = if_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rvalid_o  = d_rvalid_q;
  assign d_rdata_o   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic        d_gnt_o;
  logic        d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;
  logic        busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .STARVE_LIMIT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_gnt_o   (if_gnt_o),
    .if_rvalid_o(if_rvalid_o),
    .if_rdata_o (if_rdata_o),
    .d_req_i    (d_req_i),
    .d_we_i     (d_we_i),
    .d_addr_i   (d_addr_i),
    .d_wdata_i  (d_wdata_i),
    .d_gnt_o    (d_gnt_o),
    .d_rvalid_o (d_rvalid_o),
    .d_rdata_o  (d_rdata_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i),
    .mem_rdata_i(mem_rdata_i),
    .busy_o     (busy_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_gnt;

  initial begin
    rst = 1'b1; if_req_i = 1'b0; if_addr_i = '0; d_req_i = 1'b0; d_we_i = 1'b0;
    d_addr_i = '0; d_wdata_i = '0; mem_ready_i = 1'b0; mem_rdata_i = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    check("rst_busy",    {31'd0, busy_o}, 32'd0);
    check("rst_rvalid",  {30'd0, if_rvalid_o, d_rvalid_o}, 32'd0);
    check("rst_rdata",   if_rdata_o | d_rdata_o | mem_addr_o | mem_wdata_o, 32'd0);

    // 1: lone IF read, zero-wait memory
    if_req_i = 1'b1; if_addr_i = 32'h10;
    #1 check("t1_if_gnt_c0", {31'd0, if_gnt_o}, 32'd1);
    tick();
    if_req_i = 1'b0; mem_ready_i = 1'b1; mem_rdata_i = 32'h13;
    check("t1_mem_req_c1", {31'd0, mem_req_o}, 32'd1);
    check("t1_mem_addr",   mem_addr_o, 32'h10);
    check("t1_mem_we",     {31'd0, mem_we_o}, 32'd0);
    tick();
    mem_ready_i = 1'b0;
    check("t1_if_rvalid_c2", {31'd0, if_rvalid_o}, 32'd1);
    check("t1_if_rdata",     if_rdata_o, 32'h13);
    check("t1_d_rvalid",     {31'd0, d_rvalid_o}, 32'd0);
    check("t1_mem_req_c2",   {31'd0, mem_req_o}, 32'd0);
    tick();
    check("t1_if_rvalid_c3", {31'd0, if_rvalid_o}, 32'd0);
    check("t1_rdata_hold",   if_rdata_o, 32'h13);

    // 2: IF and data load in the same cycle; IF issues back-to-back on completion
    if_req_i = 1'b1; if_addr_i = 32'h20; d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h80;
    #1 check("t2_gnt_c0", {30'd0, if_gnt_o, d_gnt_o}, 32'b01);
    tick();
    d_req_i = 1'b0;
    check("t2_mem_addr_d", mem_addr_o, 32'h80);
    #1 check("t2_if_wait", {31'd0, if_gnt_o}, 32'd0);
    tick();
    check("t2_if_wait2", {31'd0, if_gnt_o}, 32'd0);
    mem_ready_i = 1'b1; mem_rdata_i = 32'hAAAA_0001;
    #1 check("t2_if_gnt_on_done", {31'd0, if_gnt_o}, 32'd1);
    tick();
    if_req_i = 1'b0; mem_rdata_i = 32'h5555_0002;
    check("t2_d_rvalid",   {31'd0, d_rvalid_o}, 32'd1);
    check("t2_d_rdata",    d_rdata_o, 32'hAAAA_0001);
    check("t2_mem_req_if", {31'd0, mem_req_o}, 32'd1);
    check("t2_mem_addr_if", mem_addr_o, 32'h20);
    tick();
    mem_ready_i = 1'b0;
    check("t2_if_rvalid", {31'd0, if_rvalid_o}, 32'd1);
    check("t2_if_rdata",  if_rdata_o, 32'h5555_0002);
    check("t2_d_rvalid_end", {31'd0, d_rvalid_o}, 32'd0);
    check("t2_idle", {30'd0, busy_o, mem_req_o}, 32'd0);

    // 3: store with three wait cycles; issue registers must hold
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h100; d_wdata_i = 32'hDEADBEEF;
    #1 check("t3_d_gnt", {31'd0, d_gnt_o}, 32'd1);
    tick();
    d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = 32'h200; d_wdata_i = 32'h0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t3_hold_we_%0d", i),    {31'd0, mem_we_o}, 32'd1);
      check($sformatf("t3_hold_addr_%0d", i),  mem_addr_o, 32'h100);
      check($sformatf("t3_hold_wdata_%0d", i), mem_wdata_o, 32'hDEADBEEF);
      check($sformatf("t3_no_rvalid_%0d", i),  {31'd0, d_rvalid_o}, 32'd0);
      tick();
    end
    mem_ready_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    tick();
    mem_ready_i = 1'b0;
    check("t3_d_rvalid", {31'd0, d_rvalid_o}, 32'd1);
    check("t3_d_rdata_store", d_rdata_o, 32'd0);
    tick();
    check("t3_d_rvalid_once", {31'd0, d_rvalid_o}, 32'd0);

    // 4: reset during a wait-state load abandons the access
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h40;
    tick();
    d_req_i = 1'b0;
    tick();
    check("t4_busy_before", {31'd0, busy_o}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_mem_req_after_rst", {31'd0, mem_req_o}, 32'd0);
    check("t4_busy_after_rst",    {31'd0, busy_o}, 32'd0);
    mem_ready_i = 1'b1; mem_rdata_i = 32'h4444_4444;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("t4_no_rvalid_%0d", i), {31'd0, d_rvalid_o}, 32'd0);
    end
    mem_ready_i = 1'b0;

    // 6: ready pulse while idle changes nothing
    tick();
    mem_ready_i = 1'b1;
    tick();
    mem_ready_i = 1'b0;
    check("t6_idle_rvalid", {30'd0, if_rvalid_o, d_rvalid_o}, 32'd0);
    check("t6_idle_state",  {30'd0, busy_o, mem_req_o}, 32'd0);

    // 5: both requesters saturating a zero-wait memory
    tick();
    if_req_i = 1'b1; if_addr_i = 32'h30; d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h90;
    mem_ready_i = 1'b1; mem_rdata_i = 32'h7;
    for (int c = 0; c < 10; c++) begin
      #1;
`ifdef MEMARB_STARVE_GUARD_EN
      exp_gnt = (c == 4 || c == 9) ? 2'b10 : 2'b01;
`else
      exp_gnt = 2'b01;
`endif
      check($sformatf("t5_gnt_c%0d", c), {30'd0, if_gnt_o, d_gnt_o}, {30'd0, exp_gnt});
      tick();
    end
    if_req_i = 1'b0; d_req_i = 1'b0;
    tick();
    mem_ready_i = 1'b0;
    tick();
    check("t5_drained", {30'd0, busy_o, mem_req_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, variable-latency memory between the pipeline's instruction-fetch (IF) requester and its load/store (MEM-stage) requester.
- Sequences each access with a req/ready handshake on the memory side.
- Returns read data or write completion to the requester that issued the access.
- Sits between the PC/IF_ID fetch path, the EX_MEM data path and the unified memory. It generates the per-port grants the pipeline uses as stall qualifiers.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, consecutive data grants allowed while IF waits before IF is forced ahead (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req_i  in  1  IF read request; held until if_gnt_o
- if_addr_i  in  ADDR_W  fetch address
- if_gnt_o  out  1  request accepted this cycle
- if_rvalid_o  out  1  one-cycle pulse, fetch data valid
- if_rdata_o  out  DATA_W  fetched instruction
- d_req_i  in  1  data request; held until d_gnt_o
- d_we_i  in  1  1=store, 0=load
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  store data
- d_gnt_o  out  1  request accepted this cycle
- d_rvalid_o  out  1  one-cycle pulse, load data valid or store complete
- d_rdata_o  out  DATA_W  load data; 0 for stores
- mem_req_o  out  1  memory request, registered
- mem_we_o  out  1  write enable, registered
- mem_addr_o  out  ADDR_W  registered address
- mem_wdata_o  out  DATA_W  registered write data
- mem_ready_i  in  1  memory completes current access this cycle
- mem_rdata_i  in  DATA_W  read data, valid with mem_ready_i
- busy_o  out  1  access outstanding (state != IDLE)

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: all outputs are 0, state = IDLE, owner = none, starve counter = 0.
- States:
  - IDLE: no access outstanding.
  - BUSY_IF: memory owned by IF.
  - BUSY_D: memory owned by data.
- Grant window:
  - Grants are combinational, in the same cycle as the request.
  - A grant window is open when state = IDLE, or when state is BUSY_* and mem_ready_i = 1 (back-to-back issue, no bubble).
- Arbitration in an open window: data has fixed priority over IF. At most one gnt_o is high per cycle.
- Issue on the edge after a grant:
  - mem_req_o = 1.
  - mem_we_o, mem_addr_o and mem_wdata_o are latched from the granted port (for IF: we = 0, wdata = 0).
  - state moves to BUSY_IF or BUSY_D.
- Hold rule: mem_* outputs stay stable while mem_req_o = 1 and mem_ready_i = 0.
- Completion: mem_ready_i sampled high with mem_req_o = 1 produces, on the next edge:
  - the owner's rvalid pulse, high for exactly 1 cycle;
  - the owner's rdata, loaded from mem_rdata_i (d_rdata_o = 0 for stores);
  - mem_req_o is deasserted unless a new grant happened in the same cycle.
- Latency: with a request at cycle N and mem_ready_i high in the first cycle of mem_req_o:
  - gnt at N;
  - mem_req_o at N+1;
  - rvalid at N+2.
  - Throughput is one access per cycle under a zero-wait memory.
- mem_ready_i while mem_req_o = 0 is ignored.
- Simultaneous events: completion of one port and grant of the other in the same cycle is legal. The rvalid of the finishing port and mem_req_o for the new port are both high on the following cycle.
- A requester that drops its req before its gnt forfeits it; no access is issued.
- Reset mid-access: the outstanding access is abandoned. No rvalid is produced and mem_req_o is low after the reset edge.
- rdata outputs hold their last value between rvalid pulses.

Optional Feature:
- Macro: MEMARB_STARVE_GUARD_EN.
- With the macro defined:
  - a 3-bit saturating counter increments on each d_gnt_o while if_req_i = 1 and IF is not granted;
  - the counter clears on if_gnt_o, or whenever if_req_i = 0;
  - when counter >= STARVE_LIMIT, IF wins the next open window over data.
- Without the macro: pure fixed data priority; no counter is present.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state enum IDLE/BUSY_IF/BUSY_D;
  - owner encoding OWN_NONE/OWN_IF/OWN_D;
  - default widths.
- Natural sub-module: mem_arb_pick. It is combinational priority and starve-guard selection: inputs are the requests, the window and the counter; outputs are the one-hot grant.

Test Plan:
1. Lone IF read of 0x0000_0010, memory returns 0x0000_0013 with zero wait:
   - if_gnt_o at cycle 0, mem_req_o at cycle 1, if_rvalid_o at cycle 2;
   - if_rdata_o = 0x0000_0013; d_rvalid_o stays 0.
2. IF and data load requested in the same cycle:
   - d_gnt_o first and IF waits;
   - on the data completion cycle if_gnt_o = 1, mem_addr_o switches to the IF address on the next edge with no idle cycle.
3. Store of 0xDEADBEEF to 0x100, mem_ready_i delayed 3 cycles:
   - mem_we_o, mem_addr_o and mem_wdata_o are held stable for all 3 wait cycles;
   - d_rvalid_o pulses once with d_rdata_o = 0.
4. rst asserted during a wait-state load:
   - next cycle mem_req_o = 0, busy_o = 0;
   - no d_rvalid_o, even if mem_ready_i arrives afterward.
5. MEMARB_STARVE_GUARD_EN with STARVE_LIMIT = 4, data requesting continuously and IF requesting continuously:
   - 4 data grants, then if_gnt_o, then data resumes.
   - Without the macro, IF is never granted.
6. mem_ready_i pulsed while idle: no rvalid and no state change.
